// File: rtl/hamming_pkg.sv
// Shared definitions for the 32-bit Hamming SEC-DED codeword (26 data bits)
// and the background scrubber that walks memory protected by it.
package hamming_pkg;

    localparam int CW_WIDTH  = 32;
    localparam int SYN_WIDTH = 5;
    localparam int NUM_CHECK = 5;

    // Check bits sit at the power-of-two positions; bit 0 is overall parity.
    localparam int CHECK_POS [NUM_CHECK] = '{1, 2, 4, 8, 16};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_CHECK,
        ST_WR_REQ,
        ST_NEXT
    } scrub_state_e;

    typedef enum logic [1:0] {
        CLEAN,
        SEC,
        DED
    } dec_result_e;

endpackage

// File: rtl/hamming32t26d_dec.sv
// Purely combinational decoder for the 32-bit Hamming SEC-DED codeword.
// The syndrome is the XOR of the indices of all set bits. Odd overall parity
// means a single error at the syndrome position (0 = the parity bit itself).
// Even parity with a non-zero syndrome means a double error.
module hamming32t26d_dec
    import hamming_pkg::*;
(
    input  logic [CW_WIDTH-1:0]  codeword,
    output logic [SYN_WIDTH-1:0] syndrome,
    output dec_result_e          result,
    output logic [CW_WIDTH-1:0]  corrected
);

    logic parity;

    assign parity = ^codeword;

    // Each syndrome bit is the parity over every position its check bit covers.
    always_comb begin
        syndrome = '0;
        for (int k = 0; k < NUM_CHECK; k++) begin
            for (int i = 0; i < CW_WIDTH; i++) begin
                if ((i & CHECK_POS[k]) != 0) begin
                    syndrome[k] = syndrome[k] ^ codeword[i];
                end
            end
        end
    end

    // Classify the word and flip the faulty bit when it is correctable.
    always_comb begin
        result    = CLEAN;
        corrected = codeword;
        if (parity) begin
            result              = SEC;
            corrected[syndrome] = ~codeword[syndrome];
        end else if (syndrome != '0) begin
            result = DED;
        end
    end

endmodule

// File: rtl/hamming32t26d_scrubber.sv
// Background scrubber: every SCRUB_PERIOD enabled idle cycles it reads one
// word, decodes it, rewrites single-error words with the corrected codeword
// and logs double errors. Arbitration against the functional master lives
// outside this block.
// Optional macro SCRUB_WRITEBACK_EN: when defined, single errors are written
// back; when undefined the block is report-only (no writes, mem_we_o and
// mem_wdata_o held at 0, single errors still counted).
module hamming32t26d_scrubber
    import hamming_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int MEM_DEPTH    = 256,
    parameter int SCRUB_PERIOD = 1024,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [CW_WIDTH-1:0]   mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [CW_WIDTH-1:0]   mem_rdata_i,
    output logic [CNT_WIDTH-1:0]  sec_count_o,
    output logic [CNT_WIDTH-1:0]  ded_count_o,
    output logic [ADDR_WIDTH-1:0] ded_addr_o,
    output logic                  ded_irq_o,
    output logic                  pass_done_o,
    output logic                  busy_o
);

    localparam int TIMER_W = $clog2(SCRUB_PERIOD + 1);
    localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(SCRUB_PERIOD - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST   = ADDR_WIDTH'(MEM_DEPTH - 1);

    scrub_state_e          state;
    logic [TIMER_W-1:0]    timer;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [CW_WIDTH-1:0]   rdata_q;
    logic                  mem_req_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [CNT_WIDTH-1:0]  sec_q;
    logic [CNT_WIDTH-1:0]  ded_q;
    logic [ADDR_WIDTH-1:0] ded_addr_q;
    logic                  irq_q;
    logic                  pass_done_q;

    logic [SYN_WIDTH-1:0]  dec_syndrome;
    dec_result_e           dec_result;
    logic [CW_WIDTH-1:0]   dec_corrected;
    logic                  unused_dec;

`ifdef SCRUB_WRITEBACK_EN
    logic                  we_q;
    logic [CW_WIDTH-1:0]   wdata_q;
`endif

    hamming32t26d_dec u_dec (
        .codeword  (rdata_q),
        .syndrome  (dec_syndrome),
        .result    (dec_result),
        .corrected (dec_corrected)
    );

    // Scrub sequencer: pacing timer, memory handshake, decode bookkeeping.
    // The clear at the bottom overrides any same-cycle counter or flag update.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= ST_IDLE;
            timer       <= '0;
            ptr         <= '0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            sec_q       <= '0;
            ded_q       <= '0;
            ded_addr_q  <= '0;
            irq_q       <= 1'b0;
            pass_done_q <= 1'b0;
`ifdef SCRUB_WRITEBACK_EN
            we_q        <= 1'b0;
            wdata_q     <= '0;
`endif
        end else begin
            pass_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!enable_i) begin
                        timer <= '0;
                    end else if (timer == TIMER_LAST) begin
                        timer      <= '0;
                        state      <= ST_RD_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= ptr;
`ifdef SCRUB_WRITEBACK_EN
                        we_q       <= 1'b0;
`endif
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_RD_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state     <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        rdata_q <= mem_rdata_i;
                        state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state <= ST_NEXT;
                    case (dec_result)
                        SEC: begin
                            if (sec_q != '1) begin
                                sec_q <= sec_q + CNT_WIDTH'(1);
                            end
`ifdef SCRUB_WRITEBACK_EN
                            wdata_q   <= dec_corrected;
                            we_q      <= 1'b1;
                            mem_req_q <= 1'b1;
                            state     <= ST_WR_REQ;
`endif
                        end
                        DED: begin
                            if (ded_q != '1) begin
                                ded_q <= ded_q + CNT_WIDTH'(1);
                            end
                            ded_addr_q <= ptr;
                            irq_q      <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_WR_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
`ifdef SCRUB_WRITEBACK_EN
                        we_q      <= 1'b0;
`endif
                        state     <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (ptr == PTR_LAST) begin
                        ptr         <= '0;
                        pass_done_q <= 1'b1;
                    end else begin
                        ptr <= ptr + ADDR_WIDTH'(1);
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (clear_i) begin
                sec_q      <= '0;
                ded_q      <= '0;
                ded_addr_q <= '0;
                irq_q      <= 1'b0;
            end
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign sec_count_o = sec_q;
    assign ded_count_o = ded_q;
    assign ded_addr_o  = ded_addr_q;
    assign ded_irq_o   = irq_q;
    assign pass_done_o = pass_done_q;
    assign busy_o      = (state != ST_IDLE);

`ifdef SCRUB_WRITEBACK_EN
    assign mem_we_o    = we_q;
    assign mem_wdata_o = wdata_q;
    assign unused_dec  = ^dec_syndrome;
`else
    assign mem_we_o    = 1'b0;
    assign mem_wdata_o = '0;
    assign unused_dec  = ^{dec_syndrome, dec_corrected};
`endif

endmodule
